// File: rtl/fb_scanout.sv
// Framebuffer scanout: walks the frame in raster order, issues one framebuffer
// read at a time and queues {sof, rgb} pixels in a small FIFO for the video side.
// Optional build macro FB_SCANOUT_UNDERFLOW_EN adds a sticky pop-while-empty flag.
module fb_scanout #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  output logic                          fb_do_read,
  output logic [15:0]                   fb_pix_x,
  output logic [15:0]                   fb_pix_y,
  input  logic                          fb_busy,
  input  logic                          fb_done,
  input  logic [WIDTH-1:0]              fb_rgb,
  input  logic                          vid_pop,
  output logic [23:0]                   vid_rgb,
  output logic                          vid_valid,
  output logic                          vid_sof,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, REQ} state_t;

  typedef struct packed {
    logic        sof;
    logic [23:0] rgb;
  } pix_t;

  state_t           state;
  state_t           state_next;
  logic             do_read_next;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic [15:0]      x_next;
  logic [15:0]      y_next;
  pix_t             wr_pix;
  pix_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             unused_ok;

  // fb_busy is informational and only the low 24 pixel bits are consumed
  assign unused_ok = &{1'b0, fb_busy, fb_rgb};

  // State register plus the registered read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fb_do_read <= 1'b0;
    end else begin
      state      <= state_next;
      fb_do_read <= do_read_next;
    end
  end

  // Next-state: issue only when a FIFO slot is guaranteed for the result
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && slot_free) state_next = SETUP;
      SETUP:   state_next = REQ;
      REQ:     if (fb_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: strobe is high for every REQ cycle, push on completion
  always_comb begin
    do_read_next = (state_next == REQ);
    push         = (state == REQ) && fb_done;
  end

  // Raster advance with line and frame wrap
  always_comb begin
    x_next = fb_pix_x + 16'd1;
    y_next = fb_pix_y;
    if (fb_pix_x >= 16'(H_ACTIVE - 1)) begin
      x_next = 16'd0;
      if (fb_pix_y >= 16'(V_ACTIVE - 1)) y_next = 16'd0;
      else                               y_next = fb_pix_y + 16'd1;
    end
  end

  // Read coordinates move only when a pixel is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_pix_x <= 16'd0;
      fb_pix_y <= 16'd0;
    end else if (push) begin
      fb_pix_x <= x_next;
      fb_pix_y <= y_next;
    end
  end

  // FIFO write payload and handshake terms
  always_comb begin
    wr_pix.sof = (fb_pix_x == 16'd0) && (fb_pix_y == 16'd0);
    wr_pix.rgb = fb_rgb[23:0];
    slot_free  = (count < LVL_W'(FIFO_DEPTH));
    vid_valid  = (count != LVL_W'(0));
    pop        = vid_pop && vid_valid;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_pix;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of FIFO, forced to zero when empty
  always_comb begin
    vid_rgb    = vid_valid ? mem[rd_ptr].rgb : 24'd0;
    vid_sof    = vid_valid ? mem[rd_ptr].sof : 1'b0;
    fifo_level = count;
  end

`ifdef FB_SCANOUT_UNDERFLOW_EN
  // Sticky pop-while-empty flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                         underflow <= 1'b0;
    else if (vid_pop && !vid_valid)  underflow <= 1'b1;
  end
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: two instances share stimulus, one with default
// geometry and one with a 4x2 frame for wrap checks.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fb_busy;
  logic        fb_done;
  logic [31:0] fb_rgb;
  logic        vid_pop;

  logic        a_do_read, b_do_read;
  logic [15:0] a_x, a_y, b_x, b_y;
  logic [23:0] a_rgb, b_rgb;
  logic        a_valid, b_valid, a_sof, b_sof, a_uf, b_uf;
  logic [4:0]  a_level, b_level;

  int total = 0;
  int bad   = 0;

`ifdef FB_SCANOUT_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  fb_scanout dut_a (
    .clk(clk), .rst(rst), .enable(enable), .fb_do_read(a_do_read),
    .fb_pix_x(a_x), .fb_pix_y(a_y), .fb_busy(fb_busy), .fb_done(fb_done),
    .fb_rgb(fb_rgb), .vid_pop(vid_pop), .vid_rgb(a_rgb), .vid_valid(a_valid),
    .vid_sof(a_sof), .fifo_level(a_level), .underflow(a_uf)
  );

  fb_scanout #(.H_ACTIVE(4), .V_ACTIVE(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .fb_do_read(b_do_read),
    .fb_pix_x(b_x), .fb_pix_y(b_y), .fb_busy(fb_busy), .fb_done(fb_done),
    .fb_rgb(fb_rgb), .vid_pop(vid_pop), .vid_rgb(b_rgb), .vid_valid(b_valid),
    .vid_sof(b_sof), .fifo_level(b_level), .underflow(b_uf)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; fb_busy = 1'b0; fb_done = 1'b0;
    fb_rgb = 32'd0; vid_pop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for a read, hold fb_done low for 'delay' REQ cycles, then complete it
  task automatic serve_read(input int delay, input logic [31:0] rgb, input bit pop_too,
                            output logic [15:0] ax, output logic [15:0] ay,
                            output logic [15:0] bx, output logic [15:0] by);
    int waited = 0;
    ax = 'x; ay = 'x; bx = 'x; by = 'x;
    while (a_do_read !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (a_do_read !== 1'b1) begin
      bad++;
      $display("FAIL read_start: fb_do_read=%b required 1", a_do_read);
      return;
    end
    ax = a_x; ay = a_y; bx = b_x; by = b_y;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      total++;
      if (a_do_read !== 1'b1 || a_x !== ax || a_y !== ay) begin
        bad++;
        $display("FAIL req_hold: rd=%b x=%0d y=%0d required rd=1 x=%0d y=%0d",
                 a_do_read, a_x, a_y, ax, ay);
      end
    end
    fb_done = 1'b1; fb_rgb = rgb;
    if (pop_too) vid_pop = 1'b1;
    @(negedge clk);
    fb_done = 1'b0;
    if (pop_too) vid_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; fb_busy = 1'b1; fb_done = 1'b1;
    fb_rgb = 32'hFFFFFFFF; vid_pop = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (a_do_read !== 1'b0) begin bad++; $display("FAIL rst_do_read: got %b required 0", a_do_read); end
    total++; if (a_x !== 16'd0 || a_y !== 16'd0) begin bad++; $display("FAIL rst_xy: got %0d,%0d required 0,0", a_x, a_y); end
    total++; if (a_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d required 0", a_level); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", a_valid); end
    total++; if (a_rgb !== 24'd0) begin bad++; $display("FAIL rst_rgb: got %h required 0", a_rgb); end
    total++; if (a_sof !== 1'b0) begin bad++; $display("FAIL rst_sof: got %b required 0", a_sof); end
    total++; if (a_uf !== 1'b0) begin bad++; $display("FAIL rst_underflow: got %b required 0", a_uf); end
    apply_reset();
  endtask

  task automatic test_latency();
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    total++; if (a_do_read !== 1'b0 || a_valid !== 1'b0) begin bad++; $display("FAIL lat_setup: rd=%b valid=%b required 0,0", a_do_read, a_valid); end
    @(negedge clk);
    total++; if (a_do_read !== 1'b1) begin bad++; $display("FAIL lat_req: rd=%b required 1", a_do_read); end
    fb_done = 1'b1; fb_rgb = 32'hFF123456;
    @(negedge clk);
    fb_done = 1'b0; enable = 1'b0;
    total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b required 1", a_valid); end
    total++; if (a_rgb !== 24'h123456 || a_sof !== 1'b1) begin bad++; $display("FAIL lat_head: rgb=%h sof=%b required 123456,1", a_rgb, a_sof); end
    total++; if (a_level !== 5'd1 || a_do_read !== 1'b0) begin bad++; $display("FAIL lat_after: level=%0d rd=%b required 1,0", a_level, a_do_read); end
  endtask

  task automatic test_linear_fill();
    logic [15:0] ax, ay, bx, by;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      serve_read(1, 32'(i), 1'b0, ax, ay, bx, by);
      total++; if (ax !== 16'(i) || ay !== 16'd0) begin bad++; $display("FAIL fill_xy[%0d]: got %0d,%0d required %0d,0", i, ax, ay, i); end
    end
    total++; if (a_level !== 5'd16) begin bad++; $display("FAIL fill_level: got %0d required 16", a_level); end
    total++; if (a_rgb !== 24'd0 || a_sof !== 1'b1 || a_valid !== 1'b1) begin bad++; $display("FAIL fill_head: rgb=%h sof=%b valid=%b required 0,1,1", a_rgb, a_sof, a_valid); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (a_do_read !== 1'b0) begin bad++; $display("FAIL fill_stall[%0d]: rd=%b required 0", c, a_do_read); end
    end
    enable = 1'b0;
    vid_pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (a_rgb !== 24'(i) || a_sof !== (i == 0)) begin
        bad++; $display("FAIL fill_drain[%0d]: rgb=%h sof=%b required %h,%b", i, a_rgb, a_sof, 24'(i), (i == 0));
      end
      @(negedge clk);
    end
    vid_pop = 1'b0;
    total++; if (a_level !== 5'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL fill_empty: level=%0d valid=%b required 0,0", a_level, a_valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] ax, ay, bx, by;
    logic [15:0] ex, ey;
    apply_reset();
    enable = 1'b1; vid_pop = 1'b1;
    for (int k = 0; k < 9; k++) begin
      serve_read(0, 32'(k), 1'b0, ax, ay, bx, by);
      ex = 16'(k % 4);
      ey = 16'((k / 4) % 2);
      total++; if (bx !== ex || by !== ey) begin bad++; $display("FAIL wrap_xy[%0d]: got %0d,%0d required %0d,%0d", k, bx, by, ex, ey); end
      total++;
      if (b_valid !== 1'b1 || b_rgb !== 24'(k) || b_sof !== (k == 0 || k == 8) || b_level !== 5'd1 || b_do_read !== 1'b0) begin
        bad++; $display("FAIL wrap_head[%0d]: valid=%b rgb=%h sof=%b level=%0d rd=%b required 1,%h,%b,1,0",
                        k, b_valid, b_rgb, b_sof, b_level, b_do_read, 24'(k), (k == 0 || k == 8));
      end
    end
    enable = 1'b0; vid_pop = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [15:0] ax, ay, bx, by;
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    total++; if (a_do_read !== 1'b0) begin bad++; $display("FAIL drop_setup: rd=%b required 0", a_do_read); end
    enable = 1'b0;
    serve_read(4, 32'h0000AAAA, 1'b0, ax, ay, bx, by);
    total++; if (ax !== 16'd0 || ay !== 16'd0) begin bad++; $display("FAIL drop_xy: got %0d,%0d required 0,0", ax, ay); end
    total++; if (a_level !== 5'd1 || a_rgb !== 24'h00AAAA) begin bad++; $display("FAIL drop_push: level=%0d rgb=%h required 1,00aaaa", a_level, a_rgb); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (a_do_read !== 1'b0) begin bad++; $display("FAIL drop_idle[%0d]: rd=%b required 0", c, a_do_read); end
    end
    enable = 1'b1;
    serve_read(0, 32'h0000BBBB, 1'b0, ax, ay, bx, by);
    enable = 1'b0;
    total++; if (ax !== 16'd1 || ay !== 16'd0) begin bad++; $display("FAIL drop_resume: got %0d,%0d required 1,0", ax, ay); end
    total++; if (a_level !== 5'd2) begin bad++; $display("FAIL drop_level: got %0d required 2", a_level); end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] ax, ay, bx, by;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 15; i++) serve_read(0, 32'(100 + i), 1'b0, ax, ay, bx, by);
    total++; if (a_level !== 5'd15) begin bad++; $display("FAIL pp_pre_level: got %0d required 15", a_level); end
    serve_read(0, 32'd115, 1'b1, ax, ay, bx, by);
    enable = 1'b0;
    total++; if (a_level !== 5'd15) begin bad++; $display("FAIL pp_level: got %0d required 15", a_level); end
    vid_pop = 1'b1;
    for (int i = 0; i < 15; i++) begin
      total++;
      if (a_rgb !== 24'(101 + i) || a_sof !== 1'b0) begin
        bad++; $display("FAIL pp_order[%0d]: rgb=%0d sof=%b required %0d,0", i, a_rgb, a_sof, 101 + i);
      end
      @(negedge clk);
    end
    vid_pop = 1'b0;
    total++; if (a_level !== 5'd0) begin bad++; $display("FAIL pp_empty: got %0d required 0", a_level); end
  endtask

  task automatic test_underflow();
    apply_reset();
    vid_pop = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (a_uf !== UF_EXP || b_uf !== UF_EXP) begin bad++; $display("FAIL uf_set: got %b/%b required %b", a_uf, b_uf, UF_EXP); end
    total++; if (a_level !== 5'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL uf_level: level=%0d valid=%b required 0,0", a_level, a_valid); end
    vid_pop = 1'b0;
    @(negedge clk);
    total++; if (a_uf !== UF_EXP) begin bad++; $display("FAIL uf_sticky: got %b required %b", a_uf, UF_EXP); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (a_uf !== 1'b0) begin bad++; $display("FAIL uf_clear: got %b required 0", a_uf); end
  endtask

  task automatic test_reset_mid_req();
    logic [15:0] ax, ay, bx, by;
    int waited = 0;
    apply_reset();
    enable = 1'b1;
    serve_read(0, 32'd1, 1'b0, ax, ay, bx, by);
    serve_read(0, 32'd2, 1'b0, ax, ay, bx, by);
    while (a_do_read !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    total++; if (a_do_read !== 1'b1 || a_x !== 16'd2) begin bad++; $display("FAIL mid_req_enter: rd=%b x=%0d required 1,2", a_do_read, a_x); end
    rst = 1'b1; fb_done = 1'b1; fb_rgb = 32'h00DEAD00;
    @(negedge clk);
    rst = 1'b0; fb_done = 1'b0; enable = 1'b0;
    total++; if (a_do_read !== 1'b0) begin bad++; $display("FAIL mid_rd: got %b required 0", a_do_read); end
    total++; if (a_x !== 16'd0 || a_y !== 16'd0) begin bad++; $display("FAIL mid_xy: got %0d,%0d required 0,0", a_x, a_y); end
    total++; if (a_level !== 5'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL mid_level: level=%0d valid=%b required 0,0", a_level, a_valid); end
    repeat (3) @(negedge clk);
    total++; if (a_level !== 5'd0 || a_do_read !== 1'b0) begin bad++; $display("FAIL mid_after: level=%0d rd=%b required 0,0", a_level, a_do_read); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_linear_fill();
    test_wrap();
    test_enable_drop();
    test_full_pushpop();
    test_underflow();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, framebuffer data width; H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame; FIFO_DEPTH, default 16, pixel FIFO entries (power of two, at least 4).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  permits new framebuffer reads.
- fb_do_read  out  1  read request to the framebuffer.
- fb_pix_x  out  16  read column.
- fb_pix_y  out  16  read row.
- fb_busy  in  1  framebuffer busy (observed only, not required for sequencing).
- fb_done  in  1  framebuffer read complete, combinational.
- fb_rgb  in  WIDTH  read pixel; only bits [23:0] are used.
- vid_pop  in  1  consumer takes the head pixel.
- vid_rgb  out  24  head pixel.
- vid_valid  out  1  FIFO not empty.
- vid_sof  out  1  head pixel is (0,0).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- underflow  out  1  sticky pop-while-empty flag.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SETUP and REQ.
REQ-004 IDLE SHALL go to SETUP when enable=1 and fifo_level<FIFO_DEPTH; otherwise it SHALL stay in IDLE.
REQ-005 SETUP SHALL last exactly one cycle with fb_do_read=0 and coordinates stable, then go to REQ; this cycle lets the framebuffer register the address.
REQ-006 In REQ, fb_do_read SHALL be 1 and coordinates SHALL be held stable every cycle until fb_done=1 is sampled.
REQ-007 In the REQ cycle where fb_done=1, the block SHALL do all of the following, then go to IDLE:
- push {sof, fb_rgb[23:0]} into the FIFO, where sof=1 iff coordinates are (0,0);
- advance the coordinates;
- drive fb_do_read=0 from the next cycle.
REQ-008 At most one read SHALL be outstanding; the issue gate in REQ-004 guarantees a free FIFO slot for every push.
REQ-009 Coordinate advance SHALL follow these rules:
- if x<H_ACTIVE-1, x becomes x+1;
- otherwise x becomes 0 and y becomes y+1, or y becomes 0 when y=V_ACTIVE-1.
REQ-010 Deasserting enable during SETUP or REQ SHALL NOT abort the read; the read completes, pushes, and the FSM then rests in IDLE.
REQ-011 Coordinates SHALL persist across enable toggles; only rst returns them to (0,0).
REQ-012 vid_valid, vid_rgb and vid_sof SHALL be driven from the FIFO head and SHALL update the cycle after a push into an empty FIFO.
REQ-013 A pop SHALL occur only when vid_pop=1 and vid_valid=1.
REQ-014 vid_pop=1 while vid_valid=0 SHALL cause no FIFO change; underflow behaviour is given in REQ-020.
REQ-015 A simultaneous push and pop SHALL leave fifo_level unchanged and keep the FIFO in order.
REQ-016 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 Minimum latency SHALL be four cycles from IDLE with enable=1 to vid_valid=1 when fb_done arrives in the first REQ cycle: IDLE, SETUP, REQ, then vid_valid=1.

Reset
REQ-018 While rst=1, all of the following SHALL hold:
- state is IDLE;
- fb_do_read=0 and coordinates are (0,0);
- the FIFO is emptied: fifo_level=0, vid_valid=0, vid_rgb=0, vid_sof=0;
- underflow=0.
REQ-019 rst asserted mid-REQ SHALL drop fb_do_read on the next edge, discard the transaction, and discard any fb_done sampled during reset.

Configuration
REQ-020 The macro FB_SCANOUT_UNDERFLOW_EN SHALL control underflow detection:
- defined: underflow sets on any vid_pop=1 with vid_valid=0 and stays set until rst;
- undefined: underflow is tied to 0 and no detection logic is built.

Verification
REQ-021 Scenario, linear fill: enable=1, vid_pop=0, fb_done one cycle after every fb_do_read rise, fb_rgb=pixel index -> 16 reads at (0,0)..(15,0); fifo_level reaches 16; no further fb_do_read; head vid_rgb=0 with vid_sof=1.
REQ-022 Scenario, line and frame wrap: H_ACTIVE=4, V_ACTIVE=2, continuous vid_pop -> read coordinate order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1),(0,0); vid_sof=1 on pixels 0 and 8 only.
REQ-023 Scenario, enable drop mid-read: deassert enable in the SETUP cycle, fb_done 5 cycles later -> that pixel is pushed, fb_do_read stays 0 afterwards; re-enable continues at x+1.
REQ-024 Scenario, full-level push/pop: FIFO at 15, a push and a pop in the same cycle -> fifo_level stays 15 and output order is preserved.
REQ-025 Scenario, underflow: vid_pop=1 with FIFO empty -> underflow=1 with the macro defined and 0 without it; fifo_level stays 0; rst clears underflow.
REQ-026 Scenario, reset mid-REQ: rst pulsed for one cycle during REQ, fb_done=1 in the same cycle -> no push, coordinates (0,0), fb_do_read=0 the next cycle.
